// File: rtl/blake512_pkg.sv
// Shared BLAKE-512 constants, widths and the output (finalization) transform.
// Used by the initialization, round and output stages of the core.
package blake512_pkg;

    localparam int WORD_W   = 64;
    localparam int STATE_W  = 1024;
    localparam int DIGEST_W = 512;
    localparam int N_HWORDS = DIGEST_W / WORD_W;

    localparam logic [WORD_W-1:0] IV [N_HWORDS] = '{
        64'h6A09E667F3BCC908,
        64'hBB67AE8584CAA73B,
        64'h3C6EF372FE94F82B,
        64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1,
        64'h9B05688C2B3E6C1F,
        64'h1F83D9ABFB41BD6B,
        64'h5BE0CD19137E2179
    };

    localparam logic [WORD_W-1:0] U [16] = '{
        64'h243F6A8885A308D3,
        64'h13198A2E03707344,
        64'hA4093822299F31D0,
        64'h082EFA98EC4E6C89,
        64'h452821E638D01377,
        64'hBE5466CF34E90C6C,
        64'hC0AC29B7C97C50DD,
        64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B,
        64'hD1310BA698DFB5AC,
        64'h2FFD72DBD01ADFB7,
        64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99,
        64'h24A19947B3916CF7,
        64'h0801F2E2858EFC16,
        64'h636920D871574E69
    };

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    // Zero-salt output transform: h'[i] = h[i] ^ v[i] ^ v[i+8].
    function automatic logic [DIGEST_W-1:0] blake_finalize(
        input logic [DIGEST_W-1:0] h,
        input logic [STATE_W-1:0]  v
    );
        return h ^ v[STATE_W-1:DIGEST_W] ^ v[DIGEST_W-1:0];
    endfunction

endpackage

// File: rtl/blake_digest_ser.sv
// Serializes the registered 512-bit digest into BEATS beats, most significant first.
// Stream: a beat transfers on the edge where valid & ready; data/last hold while stalled.
module blake_digest_ser
    import blake512_pkg::*;
#(
    parameter int OUT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                ready,
    output logic                valid,
    output logic [OUT_W-1:0]    data,
    output logic                last,
    output ser_state_t          state
);

    localparam int BEATS = DIGEST_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(BEATS - 1);

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             at_last;

    assign state   = state_q;
    assign at_last = (cnt_q == LAST_K);
    assign accept  = (state_q == SER_SEND) && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE: if (start) state_d = SER_SEND;
            SER_SEND: if (accept && at_last) state_d = SER_IDLE;
            default:  state_d = SER_IDLE;
        endcase
    end

    // The counter saturates at LAST_K; leaving SEND on the last accept keeps it in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == SER_IDLE) && start) begin
            cnt_q <= '0;
        end else if (accept && !at_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        valid = (state_q == SER_SEND);
        last  = valid && at_last;
        data  = '0;
        if (valid) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    data = digest[DIGEST_W-1-i*OUT_W -: OUT_W];
                end
            end
        end
    end

endmodule

// File: rtl/blake_digest_out.sv
// BLAKE-512 output stage: captures final state v, applies h ^ v_lo ^ v_hi and
// presents the digest both in parallel and as a valid/ready beat stream.
module blake_digest_out
    import blake512_pkg::*;
#(
    parameter int OUT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v_valid,
    input  logic [STATE_W-1:0]  v_in,
    input  logic [DIGEST_W-1:0] h_in,
    output logic                busy,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic [OUT_W-1:0]    dout_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                overrun
);

    ser_state_t ser_state;
    logic       capture;

    assign busy    = (ser_state == SER_SEND);
    assign capture = v_valid && !busy;

    // A v_valid while busy (including on the final accept) is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            digest       <= '0;
            digest_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            digest_valid <= capture;
            if (capture) begin
                digest <= blake_finalize(h_in, v_in);
            end
            if (v_valid && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    blake_digest_ser #(
        .OUT_W (OUT_W)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .start  (capture),
        .digest (digest),
        .ready  (dout_ready),
        .valid  (dout_valid),
        .data   (dout_data),
        .last   (dout_last),
        .state  (ser_state)
    );

endmodule

// File: tb/tb_blake_digest_out.sv
// Bench for blake_digest_out at beat widths 64, 128 and 512 sharing one stimulus stream.
module tb_blake_digest_out;

    logic          clk = 1'b0;
    logic          rst;
    logic          v_valid;
    logic [1023:0] v_in;
    logic [511:0]  h_in;
    logic          dout_ready;

    logic          busy_a, busy_b, busy_c;
    logic [511:0]  dig_a, dig_b, dig_c;
    logic          dv_a, dv_b, dv_c;
    logic [63:0]   data_a;
    logic [127:0]  data_b;
    logic [511:0]  data_c;
    logic          val_a, val_b, val_c;
    logic          last_a, last_b, last_c;
    logic          ovr_a, ovr_b, ovr_c;

    always #5 clk = ~clk;

    blake_digest_out #(.OUT_W(64)) u64 (
        .clk(clk), .rst(rst), .v_valid(v_valid), .v_in(v_in), .h_in(h_in),
        .busy(busy_a), .digest(dig_a), .digest_valid(dv_a), .dout_data(data_a),
        .dout_valid(val_a), .dout_ready(dout_ready), .dout_last(last_a), .overrun(ovr_a)
    );
    blake_digest_out #(.OUT_W(128)) u128 (
        .clk(clk), .rst(rst), .v_valid(v_valid), .v_in(v_in), .h_in(h_in),
        .busy(busy_b), .digest(dig_b), .digest_valid(dv_b), .dout_data(data_b),
        .dout_valid(val_b), .dout_ready(dout_ready), .dout_last(last_b), .overrun(ovr_b)
    );
    blake_digest_out #(.OUT_W(512)) u512 (
        .clk(clk), .rst(rst), .v_valid(v_valid), .v_in(v_in), .h_in(h_in),
        .busy(busy_c), .digest(dig_c), .digest_valid(dv_c), .dout_data(data_c),
        .dout_valid(val_c), .dout_ready(dout_ready), .dout_last(last_c), .overrun(ovr_c)
    );

    localparam int W [3] = '{64, 128, 512};
    localparam logic [511:0] IV_D = {
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
    };

    logic         act_busy [3];
    logic [511:0] act_dig  [3];
    logic         act_dv   [3];
    logic [511:0] act_data [3];
    logic         act_val  [3];
    logic         act_last [3];
    logic         act_ovr  [3];

    always_comb begin
        act_busy[0] = busy_a; act_busy[1] = busy_b; act_busy[2] = busy_c;
        act_dig[0]  = dig_a;  act_dig[1]  = dig_b;  act_dig[2]  = dig_c;
        act_dv[0]   = dv_a;   act_dv[1]   = dv_b;   act_dv[2]   = dv_c;
        act_data[0] = {448'b0, data_a};
        act_data[1] = {384'b0, data_b};
        act_data[2] = data_c;
        act_val[0]  = val_a;  act_val[1]  = val_b;  act_val[2]  = val_c;
        act_last[0] = last_a; act_last[1] = last_b; act_last[2] = last_c;
        act_ovr[0]  = ovr_a;  act_ovr[1]  = ovr_b;  act_ovr[2]  = ovr_c;
    end

    int n_checks = 0;
    int n_err    = 0;
    int acc64    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word-by-word transform over h0..h7 and v0..v15.
    function automatic logic [511:0] model_final(input logic [511:0] h, input logic [1023:0] v);
        logic [511:0] r;
        logic [63:0]  hw, vlo, vhi;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            hw  = h[511-64*i -: 64];
            vlo = v[1023-64*i -: 64];
            vhi = v[511-64*i -: 64];
            r[511-64*i -: 64] = hw ^ vlo ^ vhi;
        end
        return r;
    endfunction

    function automatic logic [511:0] beat_of(input logic [511:0] d, input int w, input int k);
        logic [511:0] one;
        logic [511:0] mask;
        one  = 512'd1;
        mask = (one << w) - one;
        return (d >> (512 - (k + 1) * w)) & mask;
    endfunction

    // Scoreboard: one expected-beat queue per width plus digest/pulse/overrun state.
    logic [511:0] exp_q [3][$];
    logic [511:0] m_dig [3];
    logic         m_dv  [3];
    logic         m_ov  [3];
    logic         m_bz;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_q[i].delete();
                m_dig[i] = '0;
                m_dv[i]  = 1'b0;
                m_ov[i]  = 1'b0;
            end else begin
                m_bz    = (exp_q[i].size() != 0);
                m_dv[i] = 1'b0;
                if (m_bz && dout_ready) void'(exp_q[i].pop_front());
                if (v_valid) begin
                    if (m_bz) begin
                        m_ov[i] = 1'b1;
                    end else begin
                        m_dig[i] = model_final(h_in, v_in);
                        m_dv[i]  = 1'b1;
                        for (int k = 0; k < 512 / W[i]; k++)
                            exp_q[i].push_back(beat_of(m_dig[i], W[i], k));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy_w%0d", W[i]), {511'b0, act_busy[i]}, {511'b0, exp_q[i].size() != 0});
                chk($sformatf("dout_valid_w%0d", W[i]), {511'b0, act_val[i]}, {511'b0, exp_q[i].size() != 0});
                chk($sformatf("digest_w%0d", W[i]), act_dig[i], m_dig[i]);
                chk($sformatf("digest_valid_w%0d", W[i]), {511'b0, act_dv[i]}, {511'b0, m_dv[i]});
                chk($sformatf("overrun_w%0d", W[i]), {511'b0, act_ovr[i]}, {511'b0, m_ov[i]});
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("dout_data_w%0d", W[i]), act_data[i], exp_q[i][0]);
                    chk($sformatf("dout_last_w%0d", W[i]), {511'b0, act_last[i]}, {511'b0, exp_q[i].size() == 1});
                end
            end
        end
        if (val_a && dout_ready) acc64++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [511:0] h, input logic [1023:0] v);
        v_valid = 1'b1;
        h_in    = h;
        v_in    = v;
        step();
        v_valid = 1'b0;
        v_in    = '0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            if (!busy_a && !busy_b && !busy_c) return;
            step();
        end
        chk("idle_timeout", 512'd1, 512'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [1023:0] v2;
        rst = 1'b1; v_valid = 1'b0; v_in = '0; h_in = '0; dout_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", {511'b0, busy_a}, 512'd0);
        chk("rst_digest", dig_a, 512'd0);
        chk("rst_dout_valid", {511'b0, val_a}, 512'd0);
        chk("rst_dout_data", {448'b0, data_a}, 512'd0);
        chk("rst_dout_last", {511'b0, last_a}, 512'd0);
        chk("rst_overrun", {511'b0, ovr_a}, 512'd0);
        chk("rst_digest_valid", {511'b0, dv_a}, 512'd0);
        step();

        // IV passthrough with ready held high
        acc64 = 0;
        pulse(IV_D, '0);
        @(negedge clk);
        chk("t1_digest_valid", {511'b0, dv_a}, 512'd1);
        chk("t1_beat0", {448'b0, data_a}, {448'b0, 64'h6A09E667F3BCC908});
        chk("t1_last0", {511'b0, last_a}, 512'd0);
        chk("t6_w128_beat0", {384'b0, data_b}, {384'b0, 128'h6A09E667F3BCC908BB67AE8584CAA73B});
        chk("t6_w512_beat", data_c, dig_c);
        chk("t6_w512_last", {511'b0, last_c}, 512'd1);
        for (int k = 0; k < 7; k++) step();
        @(negedge clk);
        chk("t1_beat7", {448'b0, data_a}, {448'b0, 64'h5BE0CD19137E2179});
        chk("t1_last7", {511'b0, last_a}, 512'd1);
        step();
        wait_idle();
        chk("t1_accepted", 512'(acc64), 512'd8);

        // XOR transform: v0 all ones, v8 = 0F.., h = 0
        v2 = '0;
        v2[1023:960] = 64'hFFFFFFFFFFFFFFFF;
        v2[511:448]  = 64'h0F0F0F0F0F0F0F0F;
        pulse('0, v2);
        @(negedge clk);
        chk("t2_beat0", {448'b0, data_a}, {448'b0, 64'hF0F0F0F0F0F0F0F0});
        step();
        @(negedge clk);
        chk("t2_beat1", {448'b0, data_a}, 512'd0);
        wait_idle();

        // Backpressure: ready 1,0,0,1,0,0,...
        acc64 = 0;
        pulse(IV_D, '0);
        for (int c = 0; c < 60; c++) begin
            if (!busy_a && !busy_b && !busy_c) break;
            dout_ready = (c % 3 == 0);
            step();
        end
        dout_ready = 1'b1;
        wait_idle();
        chk("t3_accepted", 512'(acc64), 512'd8);

        // Overrun during SEND; w512 is already idle and captures the second pulse
        pulse(IV_D, '0);
        step(); step();
        pulse(IV_D, {1024{1'b1}});
        wait_idle();
        chk("t4_overrun", {511'b0, ovr_a}, 512'd1);
        chk("t4_digest_kept", dig_a, IV_D);
        for (int k = 0; k < 3; k++) step();
        chk("t4_overrun_sticky", {511'b0, ovr_a}, 512'd1);

        // Reset after three accepted beats
        pulse(IV_D, '0);
        step(); step(); step();
        do_reset();
        @(negedge clk);
        chk("t5_dout_valid", {511'b0, val_a}, 512'd0);
        chk("t5_busy", {511'b0, busy_a}, 512'd0);
        chk("t5_digest", dig_a, 512'd0);
        chk("t5_overrun", {511'b0, ovr_a}, 512'd0);
        step();
        pulse(IV_D, '0);
        @(negedge clk);
        chk("t5_restart_beat0", {448'b0, data_a}, {448'b0, 64'h6A09E667F3BCC908});
        wait_idle();

        // v_valid on the edge that accepts the last beat is dropped
        pulse(IV_D, '0);
        for (int k = 0; k < 7; k++) step();
        pulse('0, {1024{1'b1}});
        @(negedge clk);
        chk("t7_busy_after_last", {511'b0, busy_a}, 512'd0);
        chk("t7_overrun", {511'b0, ovr_a}, 512'd1);
        chk("t7_digest_kept", dig_a, IV_D);
        wait_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
